// File: rtl/sysreg_access_ctrl_pkg.sv
// Shared instruction-decode types and helpers for MTS/MFS system-register access.
package sysreg_access_ctrl_pkg;

    typedef logic [31:0] InsnOpcode;

    localparam logic [7:0] OPC_MFS = 8'h0C;
    localparam logic [7:0] OPC_MTS = 8'h0D;

    // System-register id: group, minimum privilege level, index within group.
    typedef struct packed {
        logic [2:0] grp;
        logic [1:0] pl;
        logic [4:0] idx;
    } SysRegId;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ILLEGAL = 2'd1,
        FC_PRIV    = 2'd2,
        FC_TIMEOUT = 2'd3
    } SysRegFaultCause;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WB    = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4,
        ST_DRAIN = 3'd5
    } SysRegAccState;

    typedef struct packed {
        logic    is_mfs;
        logic    is_mts;
        SysRegId id;
        logic [4:0] rd;
    } SysRegDec;

    // MTS/MFS detect plus sysreg-operand and rd extraction in one pass.
    // MTS splits the id across two opcode fields to leave room for ra.
    function automatic SysRegDec sysreg_decode(InsnOpcode op);
        SysRegDec d;
        d.is_mfs = (op[31:23] == 9'd0) && (op[7:0] == OPC_MFS);
        d.is_mts = (op[31:23] == 9'd0) && (op[7:0] == OPC_MTS);
        d.rd     = op[22:18];
        d.id     = d.is_mts ? SysRegId'({op[22:20], op[19:18], op[12:8]})
                            : SysRegId'(op[17:8]);
        return d;
    endfunction

    // Access allowed when the register's privilege does not exceed the current one.
    function automatic logic sysreg_pl_ok(SysRegId id, logic [1:0] pl);
        return id.pl <= pl;
    endfunction

endpackage

// File: rtl/sysreg_timeout_cnt.sv
// Bus-request timeout counter: counts enabled cycles, flags the last allowed one.
module sysreg_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count waiting cycles; saturate at the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LP_LAST);

endmodule

// File: rtl/sysreg_access_ctrl.sv
// MTS/MFS sequencer between execute and the system-register bus.
//
// state | meaning
// IDLE  | ready for a new instruction
// REQ   | bus request outstanding, waiting for ack or timeout
// WB    | one-cycle MFS writeback + done pulse
// DONE  | one-cycle MTS done pulse
// FAULT | one-cycle fault pulse with latched cause
// DRAIN | flushed while on the bus; wait for ack/timeout, discard result
module sysreg_access_ctrl
    import sysreg_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_opcode,
    input  logic [31:0] in_ra_data,
    input  logic [1:0]  cur_pl,
    input  logic        flush,
    output logic        sr_req,
    output logic        sr_we,
    output logic [9:0]  sr_addr,
    output logic [31:0] sr_wdata,
    input  logic        sr_ack,
    input  logic [31:0] sr_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        fault_valid,
    output logic [1:0]  fault_cause
);

    SysRegAccState   r_state;
    SysRegAccState   w_state_nxt;
    SysRegDec        w_dec;
    SysRegId         r_addr;
    SysRegFaultCause r_cause;
    logic            r_is_mfs;
    logic            r_we;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [4:0]      r_rd;
    logic            w_pl_ok;
    logic            w_busy;
    logic            w_accept;
    logic            w_expired;

    assign w_dec    = sysreg_decode(in_opcode);
    assign w_pl_ok  = sysreg_pl_ok(w_dec.id, cur_pl);
    assign w_busy   = (r_state == ST_REQ) || (r_state == ST_DRAIN);
    assign w_accept = (r_state == ST_IDLE) && in_valid && !flush;

    // The counter keeps running across REQ -> DRAIN so a flushed request still times out.
    sysreg_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_busy),
        .i_enable (w_busy && !sr_ack),
        .o_expired(w_expired)
    );

    // Next-state decode; flush wins over a simultaneous ack.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!(w_dec.is_mfs || w_dec.is_mts) || !w_pl_ok) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (flush) begin
                    w_state_nxt = (sr_ack || w_expired) ? ST_IDLE : ST_DRAIN;
                end else if (sr_ack) begin
                    w_state_nxt = r_is_mfs ? ST_WB : ST_DONE;
                end else if (w_expired) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_DRAIN: begin
                if (sr_ack || w_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WB, ST_DONE, ST_FAULT: w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch instruction operands on accept, read data on ack, timeout cause on expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_mfs <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= '0;
            r_rdata  <= '0;
            r_cause  <= FC_NONE;
        end else begin
            if (w_accept) begin
                r_is_mfs <= w_dec.is_mfs;
                r_we     <= w_dec.is_mts;
                r_addr   <= w_dec.id;
                r_wdata  <= w_dec.is_mts ? in_ra_data : 32'd0;
                r_rd     <= w_dec.is_mfs ? w_dec.rd : 5'd0;
                r_cause  <= (w_dec.is_mfs || w_dec.is_mts) ? FC_PRIV : FC_ILLEGAL;
            end
            if ((r_state == ST_REQ) && sr_ack) begin
                r_rdata <= sr_rdata;
            end
            if ((r_state == ST_REQ) && !sr_ack && w_expired) begin
                r_cause <= FC_TIMEOUT;
            end
        end
    end

    assign in_ready    = (r_state == ST_IDLE) && !flush;
    assign sr_req      = w_busy;
    assign sr_we       = w_busy ? r_we : 1'b0;
    assign sr_addr     = w_busy ? r_addr : 10'd0;
    assign sr_wdata    = w_busy ? r_wdata : 32'd0;
    assign wb_valid    = (r_state == ST_WB) && !flush;
    assign wb_rd       = wb_valid ? r_rd : 5'd0;
    assign wb_data     = wb_valid ? r_rdata : 32'd0;
    assign done        = ((r_state == ST_WB) || (r_state == ST_DONE)) && !flush;
    assign fault_valid = (r_state == ST_FAULT) && !flush;
    assign fault_cause = fault_valid ? r_cause : FC_NONE;

endmodule

// File: tb/tb_sysreg_access_ctrl.sv
// Randomized + directed bench for sysreg_access_ctrl against a transaction-level model.
module tb_sysreg_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_opcode = 32'd0;
    logic [31:0] in_ra_data = 32'd0;
    logic [1:0]  cur_pl = 2'd0;
    logic        flush = 1'b0;
    logic        sr_ack = 1'b0;
    logic [31:0] sr_rdata = 32'd0;
    logic        in_ready, sr_req, sr_we, wb_valid, done, fault_valid;
    logic [9:0]  sr_addr;
    logic [31:0] sr_wdata, wb_data;
    logic [4:0]  wb_rd;
    logic [1:0]  fault_cause;

    int n_tests = 0;
    int n_fail  = 0;

    sysreg_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_ra_data(in_ra_data), .cur_pl(cur_pl),
        .flush(flush), .sr_req(sr_req), .sr_we(sr_we), .sr_addr(sr_addr),
        .sr_wdata(sr_wdata), .sr_ack(sr_ack), .sr_rdata(sr_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
        .fault_valid(fault_valid), .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model decode straight from the opcode layout, using shifts and masks.
    // kind: 0 illegal, 1 MFS, 2 MTS
    function automatic int mdl_kind(logic [31:0] op);
        if ((op >> 23) != 0) return 0;
        if ((op & 32'hFF) == 32'h0C) return 1;
        if ((op & 32'hFF) == 32'h0D) return 2;
        return 0;
    endfunction

    function automatic int mdl_id(logic [31:0] op);
        if (mdl_kind(op) == 2)
            return int'((((op >> 20) & 7) << 7) | (((op >> 18) & 3) << 5) | ((op >> 8) & 31));
        return int'((op >> 8) & 1023);
    endfunction

    function automatic int mdl_rd(logic [31:0] op);
        return int'((op >> 18) & 31);
    endfunction

    // Transaction-level model: a bus transaction in flight (possibly abandoned
    // by flush), or a single pending pulse (1 wb, 2 done, 3 fault).
    bit          m_busy = 0, m_drain = 0, m_is_mfs = 0, m_we = 0;
    int          m_age = 0, m_pulse = 0, m_cause = 0, m_kind = 0, m_idv = 0;
    int          m_addr = 0, m_rd = 0;
    logic [31:0] m_wdata = 0, m_rdata = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_drain = 0; m_pulse = 0; m_age = 0;
            check("rst_sr_req",   32'(sr_req), 0);
            check("rst_in_ready", 32'(in_ready), 32'(!flush));
            check("rst_sr_addr",  32'(sr_addr), 0);
            check("rst_outputs",  32'({wb_valid, done, fault_valid, fault_cause}), 0);
        end else begin
            check("in_ready",    32'(in_ready), 32'(!m_busy && m_pulse == 0 && !flush));
            check("sr_req",      32'(sr_req), 32'(m_busy));
            check("sr_we",       32'(sr_we), m_busy ? 32'(m_we) : 0);
            check("sr_addr",     32'(sr_addr), m_busy ? 32'(m_addr) : 0);
            check("sr_wdata",    sr_wdata, m_busy ? m_wdata : 0);
            check("wb_valid",    32'(wb_valid), 32'(m_pulse == 1 && !flush));
            check("wb_rd",       32'(wb_rd), (m_pulse == 1 && !flush) ? 32'(m_rd) : 0);
            check("wb_data",     wb_data, (m_pulse == 1 && !flush) ? m_rdata : 0);
            check("done",        32'(done), 32'((m_pulse == 1 || m_pulse == 2) && !flush));
            check("fault_valid", 32'(fault_valid), 32'(m_pulse == 3 && !flush));
            check("fault_cause", 32'(fault_cause), (m_pulse == 3 && !flush) ? 32'(m_cause) : 0);

            if (m_pulse != 0) begin
                m_pulse = 0;
            end else if (m_busy) begin
                if (sr_ack) begin
                    m_busy = 0;
                    if (!m_drain && !flush) begin
                        m_pulse = m_is_mfs ? 1 : 2;
                        m_rdata = sr_rdata;
                    end
                end else if (m_age == TO - 1) begin
                    m_busy = 0;
                    if (!m_drain && !flush) begin
                        m_pulse = 3; m_cause = 3;
                    end
                end else begin
                    m_age++;
                    if (flush) m_drain = 1;
                end
            end else if (in_valid && !flush) begin
                m_kind = mdl_kind(in_opcode);
                m_idv  = mdl_id(in_opcode);
                if (m_kind == 0) begin
                    m_pulse = 3; m_cause = 1;
                end else if ((m_idv / 32) % 4 > int'(cur_pl)) begin
                    m_pulse = 3; m_cause = 2;
                end else begin
                    m_busy = 1; m_drain = 0; m_age = 0;
                    m_is_mfs = (m_kind == 1);
                    m_we     = (m_kind == 2);
                    m_addr   = m_idv;
                    m_wdata  = (m_kind == 2) ? in_ra_data : 32'd0;
                    m_rd     = (m_kind == 1) ? mdl_rd(in_opcode) : 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int n_high;
    int seen_cause;
    int ack_pct;
    int sel;

    initial begin
        check("model_mfs_id", 32'(mdl_id(32'h000C250C)), 32'h025);
        check("model_mfs_rd", 32'(mdl_rd(32'h000C250C)), 32'd3);
        check("model_mts_id", 32'(mdl_id(32'h0004E50D)), 32'h025);
        check("model_nop_kind", 32'(mdl_kind(32'h00000001)), 32'd0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // MFS, ack at T+1
        in_valid = 1; in_opcode = 32'h000C250C; cur_pl = 2'd1;
        @(negedge clk); check("mfs_t_ready", 32'(in_ready), 1);
        cyc(); in_valid = 0; sr_ack = 1; sr_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("mfs_t1_req", 32'(sr_req), 1);
        check("mfs_t1_addr", 32'(sr_addr), 32'h025);
        check("mfs_t1_we", 32'(sr_we), 0);
        cyc(); sr_ack = 0;
        @(negedge clk);
        check("mfs_t2_wb_valid", 32'(wb_valid), 1);
        check("mfs_t2_wb_rd", 32'(wb_rd), 3);
        check("mfs_t2_wb_data", wb_data, 32'hDEADBEEF);
        check("mfs_t2_done", 32'(done), 1);
        cyc();
        @(negedge clk); check("mfs_t3_ready", 32'(in_ready), 1);

        // MTS, ack in fifth request cycle
        cyc(); in_valid = 1; in_opcode = 32'h0004E50D; in_ra_data = 32'h12345678;
        cyc(); in_valid = 0;
        for (int i = 1; i <= 5; i++) begin
            sr_ack = (i == 5);
            @(negedge clk);
            check("mts_req", 32'(sr_req), 1);
            check("mts_we", 32'(sr_we), 1);
            check("mts_wdata", sr_wdata, 32'h12345678);
            cyc();
        end
        sr_ack = 0;
        @(negedge clk);
        check("mts_done", 32'(done), 1);
        check("mts_no_wb", 32'(wb_valid), 0);
        check("mts_req_dropped", 32'(sr_req), 0);
        cyc();

        // Privilege fault
        in_valid = 1; in_opcode = 32'h000C250C; cur_pl = 2'd0;
        cyc(); in_valid = 0;
        @(negedge clk);
        check("priv_fault_valid", 32'(fault_valid), 1);
        check("priv_fault_cause", 32'(fault_cause), 2);
        check("priv_no_req", 32'(sr_req), 0);
        cyc();

        // Illegal opcode
        in_valid = 1; in_opcode = 32'h00000001; cur_pl = 2'd3;
        cyc(); in_valid = 0;
        @(negedge clk);
        check("ill_fault_valid", 32'(fault_valid), 1);
        check("ill_fault_cause", 32'(fault_cause), 1);
        cyc();

        // Timeout
        in_valid = 1; in_opcode = 32'h000C250C; cur_pl = 2'd1;
        cyc(); in_valid = 0;
        n_high = 0; seen_cause = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sr_req) begin
                n_high++;
            end else begin
                if (fault_valid) seen_cause = int'(fault_cause);
                break;
            end
            cyc();
        end
        check("timeout_req_cycles", 32'(n_high), 32'(TO));
        check("timeout_cause", 32'(seen_cause), 3);
        cyc();

        // Flush at T+2, ack at T+4
        in_valid = 1; in_opcode = 32'h000C250C; cur_pl = 2'd1;
        cyc(); in_valid = 0;
        @(negedge clk); check("flush_t1_pulses", 32'({wb_valid, done, fault_valid}), 0);
        cyc(); flush = 1;
        @(negedge clk); check("flush_t2_pulses", 32'({wb_valid, done, fault_valid}), 0);
        cyc(); flush = 0;
        @(negedge clk); check("flush_t3_req", 32'(sr_req), 1);
        cyc(); sr_ack = 1; sr_rdata = 32'hCAFEF00D;
        @(negedge clk); check("flush_t4_pulses", 32'({wb_valid, done, fault_valid}), 0);
        cyc(); sr_ack = 0;
        @(negedge clk);
        check("flush_t5_ready", 32'(in_ready), 1);
        check("flush_t5_pulses", 32'({wb_valid, done, fault_valid}), 0);
        cyc();

        // Reset mid-request, then a new MTS
        in_valid = 1; in_opcode = 32'h000C250C; cur_pl = 2'd1;
        cyc(); in_valid = 0;
        cyc();
        #2 rst = 1;
        #1;
        check("async_rst_req", 32'(sr_req), 0);
        check("async_rst_ready", 32'(in_ready), 1);
        cyc(); rst = 0;
        in_valid = 1; in_opcode = 32'h0004E50D; in_ra_data = 32'hAABBCCDD;
        @(negedge clk); check("post_rst_ready", 32'(in_ready), 1);
        cyc(); in_valid = 0; sr_ack = 1;
        @(negedge clk);
        check("post_rst_req", 32'(sr_req), 1);
        check("post_rst_we", 32'(sr_we), 1);
        check("post_rst_wdata", sr_wdata, 32'hAABBCCDD);
        cyc(); sr_ack = 0;
        @(negedge clk); check("post_rst_done", 32'(done), 1);
        cyc();

        // Randomized traffic, checked every cycle by the model
        ack_pct = 40;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom % 4)
                    0: ack_pct = 0;
                    1: ack_pct = 10;
                    2: ack_pct = 40;
                    default: ack_pct = 90;
                endcase
            end
            sel = int'($urandom % 10);
            if (sel < 4)      in_opcode = ($urandom & 32'h007FFF00) | 32'h0000000C;
            else if (sel < 8) in_opcode = ($urandom & 32'h007FFF00) | 32'h0000000D;
            else if (sel == 8) in_opcode = $urandom;
            else              in_opcode = $urandom | 32'h0080000C;
            in_valid   = ($urandom % 2) == 0;
            cur_pl     = 2'($urandom % 4);
            in_ra_data = $urandom;
            flush      = ($urandom % 100) < 5;
            sr_ack     = ($urandom % 100) < 32'(ack_pct);
            sr_rdata   = $urandom;
            rst        = ($urandom % 400) == 0;
            cyc();
        end
        rst = 0; in_valid = 0; flush = 0; sr_ack = 0;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
